// File: rtl/watch_set_ctrl.sv
// Time-setting controller: snapshots the running time, lets the user edit
// year..minute with mode/inc buttons, and issues a one-cycle load on commit.
module watch_set_ctrl #(
   parameter int unsigned TIMEOUT  = 30,
   parameter int unsigned YEAR_MIN = 2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        btn_mode,
   input  logic        btn_inc,
   input  logic [11:0] cur_year,
   input  logic [3:0]  cur_month,
   input  logic [4:0]  cur_day,
   input  logic [5:0]  cur_hour,
   input  logic [5:0]  cur_minute,
   output logic        set_load,
   output logic [11:0] set_year,
   output logic [3:0]  set_month,
   output logic [4:0]  set_day,
   output logic [5:0]  set_hour,
   output logic [5:0]  set_minute,
   output logic [5:0]  set_second,
   output logic        editing,
   output logic [2:0]  field,
   output logic        blink
);

   localparam int unsigned TW      = 8;
   localparam logic [11:0] YMIN    = 12'(YEAR_MIN);
   localparam logic [11:0] YMAX    = 12'(YEAR_MIN + 99);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      EDIT_YEAR  = 3'd1,
      EDIT_MONTH = 3'd2,
      EDIT_DAY   = 3'd3,
      EDIT_HOUR  = 3'd4,
      EDIT_MIN   = 3'd5
   } state_t;

   state_t          state;
   logic [TW-1:0]   to_cnt;

   logic [11:0] cap_year;
   logic [3:0]  cap_month;
   logic [4:0]  cap_day;
   logic [5:0]  cap_hour;
   logic [5:0]  cap_minute;

   // Snapshot values with out-of-range fields forced to their minimum
   assign cap_year   = (cur_year < YMIN || cur_year > YMAX) ? YMIN : cur_year;
   assign cap_month  = (cur_month == 4'd0 || cur_month > 4'd12) ? 4'd1 : cur_month;
   assign cap_day    = (cur_day == 5'd0 || cur_day > 5'd30) ? 5'd1 : cur_day;
   assign cap_hour   = (cur_hour > 6'd23) ? 6'd0 : cur_hour;
   assign cap_minute = (cur_minute > 6'd59) ? 6'd0 : cur_minute;

   assign set_second = 6'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         to_cnt     <= '0;
         set_load   <= 1'b0;
         editing    <= 1'b0;
         field      <= 3'd0;
         blink      <= 1'b0;
         set_year   <= 12'd2021;
         set_month  <= 4'd1;
         set_day    <= 5'd1;
         set_hour   <= 6'd0;
         set_minute <= 6'd0;
      end else begin
         set_load <= 1'b0;
         if (state == IDLE) begin
            blink <= 1'b0;
            if (btn_mode) begin
               state      <= EDIT_YEAR;
               editing    <= 1'b1;
               field      <= 3'd1;
               to_cnt     <= '0;
               set_year   <= cap_year;
               set_month  <= cap_month;
               set_day    <= cap_day;
               set_hour   <= cap_hour;
               set_minute <= cap_minute;
            end
         end else begin
            if (tick) blink <= ~blink;
            if (btn_mode) begin
               to_cnt <= '0;
               if (state == EDIT_MIN) begin
                  state    <= IDLE;
                  editing  <= 1'b0;
                  field    <= 3'd0;
                  blink    <= 1'b0;
                  set_load <= 1'b1;
               end else begin
                  state <= state_t'(state + 3'd1);
                  field <= field + 3'd1;
               end
            end else if (btn_inc) begin
               to_cnt <= '0;
               case (state)
                  EDIT_YEAR:  set_year   <= (set_year >= YMAX) ? YMIN : set_year + 12'd1;
                  EDIT_MONTH: set_month  <= (set_month >= 4'd12) ? 4'd1 : set_month + 4'd1;
                  EDIT_DAY:   set_day    <= (set_day >= 5'd30) ? 5'd1 : set_day + 5'd1;
                  EDIT_HOUR:  set_hour   <= (set_hour >= 6'd23) ? 6'd0 : set_hour + 6'd1;
                  EDIT_MIN:   set_minute <= (set_minute >= 6'd59) ? 6'd0 : set_minute + 6'd1;
                  default:    ;
               endcase
            end else if (tick) begin
               // Idle too long: abandon the edit, keep the shadow values
               if (to_cnt == TO_LAST) begin
                  state   <= IDLE;
                  editing <= 1'b0;
                  field   <= 3'd0;
                  blink   <= 1'b0;
                  to_cnt  <= '0;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl: directed scenarios plus random
// button/tick traffic compared against a field-level reference model.
module tb_watch_set_ctrl;

   localparam int TIMEOUT  = 30;
   localparam int YEAR_MIN = 2000;

   logic        clk = 1'b0;
   logic        rst, tick, btn_mode, btn_inc;
   logic [11:0] cur_year;
   logic [3:0]  cur_month;
   logic [4:0]  cur_day;
   logic [5:0]  cur_hour, cur_minute;
   logic        set_load, editing, blink;
   logic [11:0] set_year;
   logic [3:0]  set_month;
   logic [4:0]  set_day;
   logic [5:0]  set_hour, set_minute, set_second;
   logic [2:0]  field;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: which field is being edited (0 = none) and the edit values
   int m_field, m_y, m_mo, m_d, m_h, m_mi, m_idle_ticks;
   bit m_blink, m_load;

   always #5 clk = ~clk;

   watch_set_ctrl #(.TIMEOUT(TIMEOUT), .YEAR_MIN(YEAR_MIN)) dut (
      .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
      .cur_hour(cur_hour), .cur_minute(cur_minute),
      .set_load(set_load), .set_year(set_year), .set_month(set_month),
      .set_day(set_day), .set_hour(set_hour), .set_minute(set_minute),
      .set_second(set_second), .editing(editing), .field(field), .blink(blink)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit t, input bit bm, input bit bi);
      int cy, cmo, cd, ch, cmi;
      cy = int'(cur_year); cmo = int'(cur_month); cd = int'(cur_day);
      ch = int'(cur_hour); cmi = int'(cur_minute);
      m_load = 1'b0;
      if (r) begin
         m_field = 0; m_idle_ticks = 0; m_blink = 1'b0;
         m_y = 2021; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0;
      end else if (m_field == 0) begin
         if (bm) begin
            m_field = 1; m_idle_ticks = 0; m_blink = 1'b0;
            m_y  = (cy < YEAR_MIN || cy > YEAR_MIN + 99) ? YEAR_MIN : cy;
            m_mo = (cmo < 1 || cmo > 12) ? 1 : cmo;
            m_d  = (cd < 1 || cd > 30) ? 1 : cd;
            m_h  = (ch > 23) ? 0 : ch;
            m_mi = (cmi > 59) ? 0 : cmi;
         end
      end else begin
         if (t) m_blink = !m_blink;
         if (bm) begin
            m_idle_ticks = 0;
            if (m_field == 5) begin
               m_field = 0; m_load = 1'b1; m_blink = 1'b0;
            end else begin
               m_field++;
            end
         end else if (bi) begin
            m_idle_ticks = 0;
            case (m_field)
               1: m_y  = YEAR_MIN + ((m_y - YEAR_MIN + 1) % 100);
               2: m_mo = (m_mo % 12) + 1;
               3: m_d  = (m_d % 30) + 1;
               4: m_h  = (m_h + 1) % 24;
               5: m_mi = (m_mi + 1) % 60;
               default: ;
            endcase
         end else if (t) begin
            m_idle_ticks++;
            if (m_idle_ticks == TIMEOUT) begin
               m_field = 0; m_blink = 1'b0; m_idle_ticks = 0;
            end
         end
      end
   endtask

   // One clock: apply inputs, advance model at the edge, compare just after it
   task automatic do_cycle(input bit r, input bit t, input bit bm, input bit bi);
      rst = r; tick = t; btn_mode = bm; btn_inc = bi;
      @(posedge clk);
      model_step(r, t, bm, bi);
      #1;
      check("set_load",   32'(set_load),   32'(m_load));
      check("editing",    32'(editing),    32'(m_field != 0));
      check("field",      32'(field),      32'(m_field));
      check("blink",      32'(blink),      32'(m_blink));
      check("set_year",   32'(set_year),   32'(m_y));
      check("set_month",  32'(set_month),  32'(m_mo));
      check("set_day",    32'(set_day),    32'(m_d));
      check("set_hour",   32'(set_hour),   32'(m_h));
      check("set_minute", 32'(set_minute), 32'(m_mi));
      check("set_second", 32'(set_second), 32'd0);
   endtask

   task automatic set_cur(input int y, input int mo, input int d, input int h, input int mi);
      cur_year = 12'(y); cur_month = 4'(mo); cur_day = 5'(d);
      cur_hour = 6'(h); cur_minute = 6'(mi);
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
      set_cur(2021, 3, 15, 10, 20);
      #1;

      // Reset state
      do_cycle(1, 0, 0, 0);
      do_cycle(1, 0, 0, 0);
      check("rst_year", 32'(set_year), 32'd2021);
      check("rst_field", 32'(field), 32'd0);
      do_cycle(0, 0, 0, 1);
      check("inc_idle_ignored", 32'(set_month), 32'd1);

      // Capture on entry
      do_cycle(0, 0, 1, 0);
      check("cap_editing", 32'(editing), 32'd1);
      check("cap_field", 32'(field), 32'd1);
      check("cap_month", 32'(set_month), 32'd3);
      check("cap_day", 32'(set_day), 32'd15);
      check("cap_minute", 32'(set_minute), 32'd20);

      // Wrap of every field, then full commit
      do_cycle(1, 0, 0, 0);
      set_cur(2099, 12, 30, 23, 59);
      do_cycle(0, 0, 1, 0);
      do_cycle(0, 0, 0, 1); check("wrap_year", 32'(set_year), 32'd2000);
      do_cycle(0, 0, 1, 0);
      do_cycle(0, 0, 0, 1); check("wrap_month", 32'(set_month), 32'd1);
      do_cycle(0, 1, 1, 0);
      do_cycle(0, 0, 0, 1); check("wrap_day", 32'(set_day), 32'd1);
      do_cycle(0, 0, 1, 0);
      do_cycle(0, 0, 0, 1); check("wrap_hour", 32'(set_hour), 32'd0);
      do_cycle(0, 0, 1, 0);
      do_cycle(0, 0, 0, 1); check("wrap_minute", 32'(set_minute), 32'd0);
      do_cycle(0, 0, 1, 0);
      check("commit_load", 32'(set_load), 32'd1);
      check("commit_editing", 32'(editing), 32'd0);
      check("commit_year", 32'(set_year), 32'd2000);
      do_cycle(0, 0, 0, 0);
      check("commit_load_drop", 32'(set_load), 32'd0);
      check("commit_held_year", 32'(set_year), 32'd2000);

      // Timeout abort after TIMEOUT ticks
      set_cur(2030, 6, 10, 8, 45);
      do_cycle(0, 0, 1, 0);
      for (int i = 0; i < TIMEOUT; i++) begin
         do_cycle(0, 1, 0, 0);
         do_cycle(0, 0, 0, 0);
      end
      check("timeout_editing", 32'(editing), 32'd0);
      check("timeout_keeps_year", 32'(set_year), 32'd2030);

      // A button on the would-be timeout tick keeps the edit alive
      do_cycle(0, 0, 1, 0);
      for (int i = 0; i < TIMEOUT - 1; i++) do_cycle(0, 1, 0, 0);
      do_cycle(0, 1, 0, 1);
      check("timeout_saved", 32'(editing), 32'd1);
      for (int i = 0; i < TIMEOUT - 1; i++) do_cycle(0, 1, 0, 0);
      check("timeout_restarted", 32'(editing), 32'd1);
      do_cycle(0, 1, 0, 0);
      check("timeout_second", 32'(editing), 32'd0);

      // Mode and inc together in EDIT_HOUR: mode wins
      do_cycle(0, 0, 1, 0);
      do_cycle(0, 0, 1, 0);
      do_cycle(0, 0, 1, 0);
      do_cycle(0, 0, 1, 0);
      check("pre_both_field", 32'(field), 32'd4);
      do_cycle(0, 0, 1, 1);
      check("both_field", 32'(field), 32'd5);
      check("both_hour", 32'(set_hour), 32'd8);

      // Clamp of out-of-range capture
      do_cycle(1, 0, 0, 0);
      set_cur(1999, 0, 31, 24, 60);
      do_cycle(0, 0, 1, 0);
      check("clamp_year", 32'(set_year), 32'd2000);
      check("clamp_month", 32'(set_month), 32'd1);
      check("clamp_day", 32'(set_day), 32'd1);
      check("clamp_hour", 32'(set_hour), 32'd0);

      // Reset mid-edit in EDIT_DAY
      do_cycle(0, 0, 1, 0);
      do_cycle(0, 0, 1, 0);
      do_cycle(1, 0, 0, 0);
      check("rst_edit_editing", 32'(editing), 32'd0);
      check("rst_edit_load", 32'(set_load), 32'd0);
      check("rst_edit_year", 32'(set_year), 32'd2021);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         set_cur(1990 + int'($urandom % 130), int'($urandom % 16), int'($urandom % 32),
                 int'($urandom % 32), int'($urandom % 64));
         do_cycle(($urandom % 300) == 0, ($urandom % 3) == 0,
                  ($urandom % 10) == 0, ($urandom % 4) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/watch_set_ctrl.md
# watch_set_ctrl

Time-setting controller for the watch's clock/calendar counter. It takes debounced user button pulses and a 1 Hz tick, snapshots the running time into shadow registers, and steps the user through editing year, month, day, hour and minute. On commit it issues a single-cycle load of the edited value (seconds zeroed) into the counter. It sits between the button debouncers and the counter's load port, and also drives display blink and field-highlight.

## Interface
- TIMEOUT, 30, number of `tick` pulses without a button press before an edit is aborted (range 1..255)
- YEAR_MIN, 2000, lowest settable year; the year range is YEAR_MIN..YEAR_MIN+99
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- tick  in  1  1 Hz enable, one `clk` cycle wide
- btn_mode  in  1  debounced press pulse, one cycle wide: enter edit / advance field / commit
- btn_inc  in  1  debounced press pulse, one cycle wide: increment the selected field
- cur_year  in  12  running year from the counter
- cur_month  in  4  running month (1..12)
- cur_day  in  5  running day (1..30)
- cur_hour  in  6  running hour (0..23)
- cur_minute  in  6  running minute (0..59)
- set_load  out  1  one-cycle load strobe to the counter
- set_year  out  12  value to load
- set_month  out  4  value to load
- set_day  out  5  value to load
- set_hour  out  6  value to load
- set_minute  out  6  value to load
- set_second  out  6  value to load; constant 0
- editing  out  1  high while in any EDIT state
- field  out  3  0 = none, 1 = year, 2 = month, 3 = day, 4 = hour, 5 = minute
- blink  out  1  display blink phase for the selected field

## Operation
- States: IDLE, EDIT_YEAR, EDIT_MONTH, EDIT_DAY, EDIT_HOUR, EDIT_MIN.
- IDLE + btn_mode:
  - Go to EDIT_YEAR.
  - Capture cur_* into the shadow registers, driven on set_*.
  - Clamp any out-of-range captured field to its minimum: year to YEAR_MIN, month and day to 1, hour and minute to 0.
- EDIT_x + btn_mode: advance to the next field. EDIT_MIN + btn_mode commits: set_load = 1 for one cycle, return to IDLE.
- EDIT_x + btn_inc: increment the selected shadow field with wrap-around:
  - year: YEAR_MIN+99 → YEAR_MIN
  - month: 12 → 1
  - day: 30 → 1 (30-day months, matching the counter)
  - hour: 23 → 0
  - minute: 59 → 0
- btn_inc in IDLE is ignored.
- btn_mode and btn_inc in the same cycle: btn_mode acts, btn_inc is dropped.
- Timeout counter:
  - Cleared on entry to edit and on any button pulse.
  - Increments on `tick` while editing.
  - On the tick that would make it reach TIMEOUT, with no button that cycle: abort to IDLE with no set_load. Shadow values are retained.
  - A button in the same cycle as the timeout tick wins and clears the counter.
- blink:
  - Cleared on entry to edit.
  - Toggles on each `tick` while editing.
  - Forced to 0 in IDLE.
- set_* hold the shadow values at all times and are stable during and after set_load. set_second is always 0.
- field follows the state: 0 in IDLE, 1..5 in EDIT_YEAR..EDIT_MIN.
- rst mid-edit: return to IDLE immediately, no set_load.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE; set_load 0; editing 0; field 0; blink 0; timeout counter 0.
  - set_year 2021, set_month 1, set_day 1, set_hour 0, set_minute 0, set_second 0.
- btn_mode in IDLE at cycle N: at N+1, editing = 1, field = 1, shadow = cur_* as sampled at N.
- btn_inc at N: the field is updated at N+1. One increment per pulse.
- Commit btn_mode at N: at N+1, set_load = 1, editing = 0, field = 0. At N+2, set_load = 0.
- Timeout tick at N: at N+1, editing = 0 and set_load stays 0.
- No combinational path from any input to any output.

## Test plan
- Reset, then btn_mode with cur = 2021/03/15 10:20 → N+1: editing = 1, field = 1, set_year = 2021, set_month = 3, set_day = 15, set_hour = 10, set_minute = 20.
- In EDIT_MONTH at 12, one btn_inc → month 1. In EDIT_DAY at 30 → 1. In EDIT_HOUR at 23 → 0. In EDIT_MIN at 59 → 0. Year 2099 → 2000.
- Full walk: five btn_mode pulses → set_load high for exactly one cycle with the edited values and set_second = 0, then editing = 0 and field = 0.
- Enter edit, then 30 ticks with no button → IDLE, set_load never asserts. Repeat with btn_inc on the 30th tick → still EDIT, counter cleared.
- btn_mode and btn_inc in the same cycle in EDIT_HOUR → field becomes 5 and hour is unchanged. Captured cur_month = 0 → clamped to 1.
- rst asserted in EDIT_DAY → next cycle all outputs at their reset values, no set_load.
